// File: rtl/counter_param_updown_if.sv
// Control and status bundle for counter_param_updown; master drives the controls, slave is the counter.
interface counter_param_updown_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sync_clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             ovf_sticky;
    logic             at_bound;

    modport master (
        output sync_clr, load, load_val, en, up_dn,
        input  q, wrap, ovf_sticky, at_bound
    );

    modport slave (
        input  sync_clr, load, load_val, en, up_dn,
        output q, wrap, ovf_sticky, at_bound
    );
endinterface

// File: rtl/counter_param_updown.sv
// Up/down counter over 0..MAX_COUNT with load clamp, sync clear, registered wrap pulse and sticky overflow.
// Define COUNTER_SATURATE_EN to hold at the boundary instead of wrapping around.
module counter_param_updown #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 255
) (
    input  logic                   clk,
    input  logic                   clear_n,
    counter_param_updown_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_Q = MAX_COUNT[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (bus.sync_clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            count_d = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (count_q >= MAX_Q) begin
`ifdef COUNTER_SATURATE_EN
                    count_d = count_q;
`else
                    count_d = '0;
`endif
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
`ifdef COUNTER_SATURATE_EN
                    count_d = count_q;
`else
                    count_d = MAX_Q;
`endif
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.q          = count_q;
    assign bus.wrap       = wrap_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.at_bound   = bus.up_dn ? (count_q == MAX_Q) : (count_q == '0);
endmodule

// File: tb/tb_counter_param_updown.sv
// Directed bench: a MAX_COUNT=9 instance and a default-parameter instance share clock and reset.
module tb_counter_param_updown;
    logic clk;
    logic clear_n;
    int unsigned total;
    int unsigned bad;

    counter_param_updown_if #(.WIDTH(8)) b9 ();
    counter_param_updown_if #(.WIDTH(8)) bd ();

    counter_param_updown #(.WIDTH(8), .MAX_COUNT(9)) dut9 (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (b9.slave)
    );

    counter_param_updown #(.WIDTH(8), .MAX_COUNT(255)) dutd (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bd.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_q;
        int exp_w;
        int dn_q[4];
        int dn_w[4];
        total = 0;
        bad   = 0;
        clear_n = 1'b0;
        b9.sync_clr = 0; b9.load = 0; b9.load_val = '0; b9.en = 0; b9.up_dn = 0;
        bd.sync_clr = 0; bd.load = 0; bd.load_val = '0; bd.en = 0; bd.up_dn = 0;

        // reset state
        #12;
        chk("rst_q9", b9.q, 0);
        chk("rst_wrap9", b9.wrap, 0);
        chk("rst_ovf9", b9.ovf_sticky, 0);
        chk("rst_bound9", b9.at_bound, 1);
        chk("rst_qd", bd.q, 0);
        clear_n = 1'b1;

        // async reset mid-count at q=37
        bd.load = 1; bd.load_val = 8'd36; bd.en = 1; bd.up_dn = 1;
        tick();
        chk("ld36", bd.q, 36);
        bd.load = 0;
        tick();
        chk("cnt37", bd.q, 37);
        #2;
        clear_n = 1'b0;
        #1;
        chk("async_q", bd.q, 0);
        chk("async_wrap", bd.wrap, 0);
        chk("async_ovf", bd.ovf_sticky, 0);
        clear_n = 1'b1;
        tick();
        chk("post_rst_q", bd.q, 1);
        bd.en = 0;

        // count up 12 cycles with MAX_COUNT=9
        b9.en = 1; b9.up_dn = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
`ifdef COUNTER_SATURATE_EN
            exp_q = (i + 1 > 9) ? 9 : i + 1;
            exp_w = (i >= 9) ? 1 : 0;
`else
            exp_q = (i + 1) % 10;
            exp_w = (i == 9) ? 1 : 0;
`endif
            chk("up9_q", b9.q, exp_q);
            chk("up9_wrap", b9.wrap, exp_w);
            chk("up9_ovf", b9.ovf_sticky, (i >= 9) ? 1 : 0);
        end

        // load 2, then count down 4 cycles
        b9.en = 0; b9.load = 1; b9.load_val = 8'd2;
        tick();
        chk("ld2_q", b9.q, 2);
        chk("ld2_wrap", b9.wrap, 0);
        chk("ld2_ovf", b9.ovf_sticky, 1);
        b9.load = 0; b9.en = 1; b9.up_dn = 0;
`ifdef COUNTER_SATURATE_EN
        dn_q = '{1, 0, 0, 0};
        dn_w = '{0, 0, 1, 1};
`else
        dn_q = '{1, 0, 9, 8};
        dn_w = '{0, 0, 1, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dn_q", b9.q, dn_q[i]);
            chk("dn_wrap", b9.wrap, dn_w[i]);
            chk("dn_bound", b9.at_bound, (dn_q[i] == 0) ? 1 : 0);
        end

        // load clamp beats enable
        b9.load = 1; b9.load_val = 8'd200; b9.en = 1; b9.up_dn = 1;
        tick();
        chk("clamp_q", b9.q, 9);
        chk("clamp_wrap", b9.wrap, 0);
        chk("bound_up", b9.at_bound, 1);
        b9.up_dn = 0;
        #1;
        chk("bound_dn", b9.at_bound, 0);

        // sync_clr beats load
        b9.sync_clr = 1; b9.load_val = 8'd5;
        tick();
        chk("sclr_q", b9.q, 0);
        chk("sclr_ovf", b9.ovf_sticky, 0);
        chk("sclr_wrap", b9.wrap, 0);
        b9.sync_clr = 0; b9.load = 0; b9.en = 0;
        tick();
        chk("hold9_q", b9.q, 0);

        // default params: 260-cycle free run from 0
        bd.sync_clr = 1;
        tick();
        chk("d_clr_q", bd.q, 0);
        bd.sync_clr = 0; bd.en = 1; bd.up_dn = 1;
        for (int i = 0; i < 260; i++) begin
            tick();
`ifdef COUNTER_SATURATE_EN
            exp_q = (i + 1 > 255) ? 255 : i + 1;
            exp_w = (i >= 255) ? 1 : 0;
`else
            exp_q = (i + 1) % 256;
            exp_w = (i == 255) ? 1 : 0;
`endif
            chk("free_q", bd.q, exp_q);
            chk("free_wrap", bd.wrap, exp_w);
        end
        bd.en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
`ifdef COUNTER_SATURATE_EN
            chk("hold_q", bd.q, 255);
`else
            chk("hold_q", bd.q, 4);
`endif
            chk("hold_wrap", bd.wrap, 0);
            chk("hold_ovf", bd.ovf_sticky, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
